// File: rtl/fetch_bundle_queue.sv
// Circular FIFO of fetch bundles between FetchStage1 and decode.
// Each entry carries the bundle, its prediction info and a per-slot valid mask.
module fetch_bundle_queue #(
    parameter int PC_W   = 32,
    parameter int INST_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic                        fs1Valid_i,
    input  logic [PC_W-1:0]             pc_i,
    input  logic [4*INST_W-1:0]         bundle_i,
    input  logic [3:0]                  btbHit_i,
    input  logic [3:0]                  prediction_i,
    input  logic [4*PC_W-1:0]           targetAddr_i,
    input  logic [PC_W-1:0]             addrRAS_CP_i,
    output logic                        stall_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [PC_W-1:0]             pc_o,
    output logic [4*INST_W-1:0]         bundle_o,
    output logic [3:0]                  btbHit_o,
    output logic [3:0]                  prediction_o,
    output logic [4*PC_W-1:0]           targetAddr_o,
    output logic [PC_W-1:0]             addrRAS_CP_o,
    output logic [3:0]                  instValid_o,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [4*INST_W-1:0] bundle;
        logic [3:0]          btb_hit;
        logic [3:0]          pred;
        logic [4*PC_W-1:0]   target;
        logic [PC_W-1:0]     ras;
        logic [3:0]          mask;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         mask;
    logic               push, pop;
    entry_t             new_e, head_e;

    // A slot is live only if no earlier slot is a predicted-taken branch.
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        mask    = '0;
        for (int k = 0; k < 4; k++) begin
            mask[k] = ~blocked;
            blocked = blocked | (btbHit_i[k] & prediction_i[k]);
        end
    end

    assign stall_o = (count_q == CNT_W'(DEPTH));
    assign valid_o = (count_q != '0);
    assign push    = fs1Valid_i & ~stall_o & ~flush_i;
    assign pop     = valid_o & ready_i & ~flush_i;

    always_comb begin
        new_e.pc      = pc_i;
        new_e.bundle  = bundle_i;
        new_e.btb_hit = btbHit_i;
        new_e.pred    = prediction_i;
        new_e.target  = targetAddr_i;
        new_e.ras     = addrRAS_CP_i;
        new_e.mask    = mask;
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = new_e;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop) head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign head_e       = mem_q[head_q];
    assign pc_o         = head_e.pc;
    assign bundle_o     = head_e.bundle;
    assign btbHit_o     = head_e.btb_hit;
    assign prediction_o = head_e.pred;
    assign targetAddr_o = head_e.target;
    assign addrRAS_CP_o = head_e.ras;
    assign instValid_o  = head_e.mask;
    assign count_o      = count_q;
endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed bench for fetch_bundle_queue (default parameters, DEPTH=4).
module tb_fetch_bundle_queue;
    localparam int PC_W = 32, INST_W = 64, DEPTH = 4;

    logic                   clk = 0, reset = 0, flush_i = 0, fs1Valid_i = 0, ready_i = 0;
    logic [PC_W-1:0]        pc_i = '0, addrRAS_CP_i = '0;
    logic [4*INST_W-1:0]    bundle_i = '0;
    logic [3:0]             btbHit_i = '0, prediction_i = '0;
    logic [4*PC_W-1:0]      targetAddr_i = '0;
    logic                   stall_o, valid_o;
    logic [PC_W-1:0]        pc_o, addrRAS_CP_o;
    logic [4*INST_W-1:0]    bundle_o;
    logic [3:0]             btbHit_o, prediction_o, instValid_o;
    logic [4*PC_W-1:0]      targetAddr_o;
    logic [2:0]             count_o;
    int checks = 0, failures = 0;

    fetch_bundle_queue #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .fs1Valid_i(fs1Valid_i),
        .pc_i(pc_i), .bundle_i(bundle_i), .btbHit_i(btbHit_i), .prediction_i(prediction_i),
        .targetAddr_i(targetAddr_i), .addrRAS_CP_i(addrRAS_CP_i), .stall_o(stall_o),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .bundle_o(bundle_o),
        .btbHit_o(btbHit_o), .prediction_o(prediction_o), .targetAddr_o(targetAddr_o),
        .addrRAS_CP_o(addrRAS_CP_o), .instValid_o(instValid_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Bundle/target/RAS fields are derived from the PC so one value tags an entry.
    task automatic drive(input logic fs, input logic [31:0] pc, input logic [3:0] btb,
                         input logic [3:0] pred, input logic rdy, input logic fl);
        fs1Valid_i   = fs;
        pc_i         = pc;
        bundle_i     = {8{pc}};
        targetAddr_i = {4{pc + 32'h10}};
        addrRAS_CP_i = pc ^ 32'hFFFF;
        btbHit_i     = btb;
        prediction_i = pred;
        ready_i      = rdy;
        flush_i      = fl;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 0;
        #2;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (pc_o !== '0 || bundle_o !== '0 || instValid_o !== 4'b0 || targetAddr_o !== '0)
            begin failures++; $display("FAIL reset_fields pc=%h mask=%b exp=0", pc_o, instValid_o); end
        tick(); tick();
        reset = 1;
        tick();
    endtask

    task automatic test_basic();
        drive(1, 32'h100, 4'b0000, 4'b0000, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", valid_o); end
        checks++; if (pc_o !== 32'h100) begin failures++; $display("FAIL basic_pc got=%h exp=100", pc_o); end
        checks++; if (instValid_o !== 4'b1111) begin failures++; $display("FAIL basic_mask got=%b exp=1111", instValid_o); end
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count_o); end
        checks++; if (bundle_o !== {8{32'h100}} || targetAddr_o !== {4{32'h110}} || addrRAS_CP_o !== 32'hFEFF)
            begin failures++; $display("FAIL basic_fields bundle=%h ras=%h", bundle_o[63:0], addrRAS_CP_o); end
        drive(0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (valid_o !== 1'b0 || count_o !== 3'd0)
            begin failures++; $display("FAIL basic_pop valid=%b count=%0d exp=0/0", valid_o, count_o); end
    endtask

    task automatic test_mask();
        logic [3:0] btb  [4] = '{4'b0010, 4'b0010, 4'b0001, 4'b1000};
        logic [3:0] pred [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b1000};
        logic [3:0] exp  [4] = '{4'b0011, 4'b1111, 4'b0001, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h300 + 32'(i), btb[i], pred[i], 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (instValid_o !== exp[i] || pc_o !== 32'h300 + 32'(i))
                begin failures++; $display("FAIL mask_%0d got=%b pc=%h exp=%b", i, instValid_o, pc_o, exp[i]); end
            checks++; if (btbHit_o !== btb[i] || prediction_o !== pred[i])
                begin failures++; $display("FAIL mask_pred_%0d btb=%b pred=%b", i, btbHit_o, prediction_o); end
            drive(0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h200 + 32'(4*i), 0, 0, 0, 0);
            tick();
            if (i == 3) begin
                checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", stall_o); end
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc_o !== 32'h200 + 32'(4*i) || valid_o !== 1'b1)
                begin failures++; $display("FAIL full_pop_%0d got=%h exp=%h", i, pc_o, 32'h200 + 32'(4*i)); end
            drive(0, 0, 0, 0, 1, 0);
            tick();
            if (i == 0) begin
                checks++; if (stall_o !== 1'b0 || count_o !== 3'd3)
                    begin failures++; $display("FAIL full_unstall stall=%b count=%0d exp=0/3", stall_o, count_o); end
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count_o !== 3'd0 || valid_o !== 1'b0)
            begin failures++; $display("FAIL full_drain count=%0d valid=%b", count_o, valid_o); end
    endtask

    task automatic test_back_to_back();
        drive(1, 32'hA00, 0, 0, 0, 0); tick();
        drive(1, 32'hB00, 0, 0, 0, 0); tick();
        drive(1, 32'hC00, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", count_o); end
        checks++; if (pc_o !== 32'hB00) begin failures++; $display("FAIL b2b_head got=%h exp=b00", pc_o); end
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (pc_o !== 32'hC00 || count_o !== 3'd1)
            begin failures++; $display("FAIL b2b_next got=%h count=%0d exp=c00/1", pc_o, count_o); end
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h500 + 32'(i), 0, 0, 0, 0); tick();
        end
        drive(1, 32'h5FF, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count_o !== 3'd0 || valid_o !== 1'b0)
            begin failures++; $display("FAIL flush_state count=%0d valid=%b exp=0/0", count_o, valid_o); end
        tick();
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL flush_hold got=%0d exp=0", count_o); end
        drive(1, 32'h600, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (pc_o !== 32'h600 || count_o !== 3'd1)
            begin failures++; $display("FAIL flush_push got=%h count=%0d exp=600/1", pc_o, count_o); end
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        drive(1, 32'h700, 0, 0, 0, 0); tick();
        drive(1, 32'h704, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", count_o); end
        #2 reset = 0;
        #1;
        checks++; if (valid_o !== 1'b0 || count_o !== 3'd0 || stall_o !== 1'b0)
            begin failures++; $display("FAIL areset_now valid=%b count=%0d exp=0/0", valid_o, count_o); end
        checks++; if (pc_o !== '0) begin failures++; $display("FAIL areset_fields got=%h exp=0", pc_o); end
        tick();
        reset = 1;
        tick();
        drive(1, 32'h40, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (pc_o !== 32'h40 || count_o !== 3'd1)
            begin failures++; $display("FAIL areset_push got=%h count=%0d exp=40/1", pc_o, count_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/fetch_bundle_queue.md
FETCH_BUNDLE_QUEUE -- requirements
Module: fetch_bundle_queue

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter INST_W, default 64, meaning one instruction width (bundle = 4*INST_W).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning bundle entries; legal values are powers of two, 2..16.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port flush_i  input  1  synchronous flush of all entries.
REQ-007 The block SHALL have port fs1Valid_i  input  1  FetchStage1 bundle valid (cache hit, not stalled).
REQ-008 The block SHALL have port pc_i  input  PC_W  PC of slot 0.
REQ-009 The block SHALL have port bundle_i  input  4*INST_W  instructions; slot k at bits [k*INST_W +: INST_W].
REQ-010 The block SHALL have port btbHit_i  input  4  per-slot BTB hit.
REQ-011 The block SHALL have port prediction_i  input  4  per-slot predicted direction.
REQ-012 The block SHALL have port targetAddr_i  input  4*PC_W  per-slot predicted target.
REQ-013 The block SHALL have port addrRAS_CP_i  input  PC_W  RAS checkpoint address.
REQ-014 The block SHALL have port stall_o  output  1  back-pressure to FetchStage1.
REQ-015 The block SHALL have port valid_o  output  1  head entry valid toward decode.
REQ-016 The block SHALL have port ready_i  input  1  decode accepts head entry.
REQ-017 The block SHALL have port pc_o, bundle_o, btbHit_o, prediction_o, targetAddr_o, addrRAS_CP_o  outputs  same widths as inputs  head entry fields.
REQ-018 The block SHALL have port instValid_o  output  4  per-slot valid mask of head entry.
REQ-019 The block SHALL have port count_o  output  log2(DEPTH)+1  current occupancy.

Function
REQ-020 The block SHALL be a circular FIFO with registered head pointer, tail pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-021 The block SHALL drive stall_o = (count == DEPTH), decoded from registered state only.
REQ-022 A push SHALL occur when fs1Valid_i=1, stall_o=0 and flush_i=0; it writes all input fields plus the computed mask at tail, then advances tail.
REQ-023 The mask SHALL be computed at push: slot k valid iff no slot j<k has btbHit_i[j]&prediction_i[j]; slot 0 is always valid.
REQ-024 A pop SHALL occur when valid_o=1, ready_i=1 and flush_i=0; it advances head.
REQ-025 The block SHALL drive valid_o = (count != 0), with head fields and mask as outputs, read combinationally from storage.
REQ-026 A simultaneous push and pop SHALL leave count unchanged; a pop while full blocks any push that cycle (stall_o is already 1).
REQ-027 fs1Valid_i while stall_o=1 SHALL be ignored; FetchStage1 holds its bundle.
REQ-028 flush_i=1 SHALL zero head, tail and count at the next edge, overriding any push or pop that cycle; valid_o=0 the following cycle.
REQ-029 Latency SHALL be one cycle: a bundle pushed at edge N appears on outputs after edge N when the FIFO was empty.
REQ-030 Output fields while valid_o=0 SHALL be don't-care, but SHALL contain no X after reset.

Reset
REQ-031 reset=0 SHALL immediately clear head, tail and count, giving valid_o=0, stall_o=0 and count_o=0 without a clock edge.
REQ-032 reset=0 SHALL zero all storage entries, so all head fields read 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL land in entry 0.

Verification
REQ-034 Reset, then push pc_i=0x100 with btbHit=0000 -> valid_o=1 next cycle, pc_o=0x100, instValid_o=1111, count_o=1.
REQ-035 Push btbHit=0010, prediction=0010 -> instValid_o=0011; push btbHit=0010, prediction=0000 -> instValid_o=1111.
REQ-036 With DEPTH=4 and ready_i=0, push 5 bundles -> stall_o=1 after the 4th, 5th ignored, count_o=4; then ready_i=1 for 4 cycles -> pops in FIFO order and pointers wrap correctly.
REQ-037 Count=2 with push and pop in the same cycle -> count_o stays 2 and the next head is the older entry.
REQ-038 Count=3 with flush_i=1, fs1Valid_i=1 and ready_i=1 together -> count_o=0 and valid_o=0 next cycle, and the new bundle is not stored.
REQ-039 Count=2, assert reset=0 between clock edges -> valid_o=0 and count_o=0 immediately; after release, push pc=0x40 -> pc_o=0x40.
